// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end. Synchronises RXD, deserialises frames
// (8N1, or 8E1 when UART_RX_PARITY_EN is defined) and queues received bytes in
// a first-word-fall-through FIFO drained over a VALID/READY handshake.
// Sticky FRAME_ERR / OVERRUN / PARITY_ERR flags, cleared by CLR_ERR.
// Optional feature macro: UART_RX_PARITY_EN (even-parity check, PARITY state).
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DEPTH       = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     RXD,
  output logic [7:0]               DATA,
  output logic                     VALID,
  input  logic                     READY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FRAME_ERR,
  output logic                     OVERRUN,
  output logic                     PARITY_ERR,
  input  logic                     CLR_ERR
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rxs;

  // Two-flop synchroniser for the asynchronous RX pin; idles high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  assign rxs = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          push_q;
  logic [7:0]    push_byte;
  logic          bit_done;
  logic          stop_sample;
  logic          frame_fault_set;

  assign bit_done        = (bit_cnt == '0);
  assign stop_sample     = (state == S_STOP) && bit_done;
  assign frame_fault_set = stop_sample && !rxs;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_fault;
  logic par_fault_set;

  // Even parity: data bits XOR parity bit must be zero.
  assign par_fault     = (^shift_q) ^ par_bit;
  assign par_fault_set = stop_sample && par_fault;
`else
  logic par_fault;

  assign par_fault = 1'b0;
`endif

  // Frame deserialiser: mid-bit sampling from a down-counter reloaded each bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      push_byte <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            bit_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (bit_done) begin
            if (!rxs) begin
              state   <= S_DATA;
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            shift_q <= {rxs, shift_q[7:1]};
            bit_cnt <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            par_bit <= rxs;
            bit_cnt <= FULL_LOAD;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Return to IDLE at the stop-bit sample so back-to-back frames are caught.
          if (bit_done) begin
            push_q    <= rxs && !par_fault;
            push_byte <= shift_q;
            state     <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   cnt_next;
  logic [7:0]    head_next;
  logic          do_push;
  logic          do_pop;
  logic          fifo_full;
  logic          ovr_set;

  // Next-state pointers and head; the head bypasses memory when the byte being
  // written lands in the slot that becomes the head (empty, or last entry popped).
  always_comb begin
    do_pop    = VALID & READY;
    fifo_full = (COUNT == (AW + 1)'(DEPTH));
    do_push   = push_q & (!fifo_full | do_pop);
    ovr_set   = push_q & fifo_full & !do_pop;
    rd_next   = rd_ptr + AW'(do_pop);
    cnt_next  = COUNT + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    head_next = mem[rd_next];
    if (do_push && (wr_ptr == rd_next)) begin
      head_next = push_byte;
    end
  end

  // Storage array; written only on an accepted push.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  // Pointers, occupancy and registered head/valid outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      VALID  <= 1'b0;
      DATA   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      COUNT  <= cnt_next;
      VALID  <= (cnt_next != '0);
      DATA   <= (cnt_next != '0) ? head_next : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags (set wins over clear)
  // ---------------------------------------------------------------------------

  // Framing and overrun flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_fault_set | (FRAME_ERR & ~CLR_ERR);
      OVERRUN   <= ovr_set | (OVERRUN & ~CLR_ERR);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PARITY_ERR <= 1'b0;
    end else begin
      PARITY_ERR <= par_fault_set | (PARITY_ERR & ~CLR_ERR);
    end
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo. Expected bytes are queued
// when a frame is issued; a negedge monitor pops and compares on VALID&READY.
// Runs at a reduced bit rate (17 CLK per bit, truncated) to keep runs short.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD_R = 57_600;
  localparam int DEPTH  = 16;
  localparam int CPB    = CLK_HZ / BAUD_R;
  localparam int HALF   = CPB / 2 - 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Falling edge after P0 -> 2 sync flops -> IDLE edge -> HALF+1 edges to the
  // start check -> CPB per data/parity/stop bit -> stop sample; VALID 1 CLK later.
  localparam int LAT = HALF + 5 + (PAR_EN ? 10 : 9) * CPB;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RXD;
  logic       READY;
  logic       CLR_ERR;
  logic [7:0] DATA;
  logic       VALID;
  logic [4:0] COUNT;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .DATA      (DATA),
    .VALID     (VALID),
    .READY     (READY),
    .COUNT     (COUNT),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .PARITY_ERR(PARITY_ERR),
    .CLR_ERR   (CLR_ERR)
  );

  always #10 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned t_start  = 0;
  logic [7:0]  exp_q[$];
  bit          model_frame = 0;
  bit          model_ovr   = 0;
  bit          model_par   = 0;
  bit          lat_armed   = 0;
  bit          ready_man   = 0;
  bit          rand_en     = 0;
  bit          seen_frame  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // READY driver: either random or the value requested by the main sequence.
  initial begin
    READY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      READY = rand_en ? ($urandom_range(0, 2) == 0) : ready_man;
    end
  end

  // Monitor: pop the scoreboard whenever the DUT hands over a byte.
  always @(negedge CLK) begin
    if (RESET) begin
      if (lat_armed && VALID) begin
        check("valid_latency", int'(cyc - t_start), LAT);
        lat_armed = 0;
      end
      if (VALID && READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: actual=0x%0h required=no data", DATA);
        end else begin
          check("pop_data", DATA, exp_q.pop_front());
        end
      end
      if (FRAME_ERR) seen_frame = 1;
    end
  end

  // Reference model: a frame either yields a byte at the FIFO tail or a flag.
  task automatic model_frame_in(input logic [7:0] b, input bit stop, input bit pflip,
                                input bit pop_at_push);
    bit pbad;
    pbad = pflip && PAR_EN;
    if (!stop) model_frame = 1;
    if (pbad) model_par = 1;
    if (stop && !pbad) begin
      if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(b);
      else model_ovr = 1;
    end
  endtask

  task automatic bit_out(input logic v);
    RXD = v;
    tick(CPB);
  endtask

  // Called aligned to posedge+1; returns aligned at the end of the stop bit.
  task automatic send(input logic [7:0] b, input bit stop, input bit pflip, input bit pop_at_push);
    model_frame_in(b, stop, pflip, pop_at_push);
    t_start = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    if (PAR_EN) bit_out((^b) ^ pflip);
    bit_out(stop);
    RXD = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, FRAME_ERR, model_frame);
    check({tag, "_overrun"}, OVERRUN, model_ovr);
    check({tag, "_parity_err"}, PARITY_ERR, model_par);
  endtask

  task automatic clear_flags(input string tag);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    model_frame = 0;
    model_ovr   = 0;
    model_par   = 0;
    tick(1);
    check_flags(tag);
  endtask

  task automatic drain(input string tag);
    ready_man = 1;
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick(1);
    check({tag, "_drained"}, exp_q.size(), 0);
    tick(4);
    ready_man = 0;
    tick(3);
    check({tag, "_count_empty"}, COUNT, 0);
    check({tag, "_valid_empty"}, VALID, 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bit         stop;
    bit         pflip;
    RXD     = 1'b1;
    RESET   = 1'b0;
    CLR_ERR = 1'b0;
    tick(4);
    check("rst_data", DATA, 0);
    check("rst_valid", VALID, 0);
    check("rst_count", COUNT, 0);
    check_flags("rst");
    RESET = 1'b1;
    tick(4);

    // Single byte, latency to VALID and head contents.
    lat_armed = 1;
    send(8'h55, 1, 0, 0);
    tick(2);
    check("t1_valid_rose", lat_armed, 0);
    check("t1_data", DATA, 8'h55);
    check("t1_count", COUNT, 1);
    check_flags("t1");
    drain("t1");

    // Short low glitch is rejected at the start-bit check.
    RXD = 1'b0;
    tick(4);
    RXD = 1'b1;
    tick(3 * CPB);
    check("t2_count", COUNT, 0);
    check("t2_valid", VALID, 0);
    check_flags("t2");

    // Stop bit low: framing error, byte discarded, then cleared.
    send(8'hA3, 0, 0, 0);
    tick(CPB);
    check("t3_count", COUNT, 0);
    check_flags("t3");
    clear_flags("t3_clr");

    // Framing fault while CLR_ERR is held high: the set still lands.
    CLR_ERR = 1'b1;
    seen_frame = 0;
    send(8'h5A, 0, 0, 0);
    tick(CPB);
    CLR_ERR = 1'b0;
    model_frame = 0;
    tick(1);
    check("t3_set_beats_clear", seen_frame, 1);
    check_flags("t3b");

    // 17 back-to-back bytes with no pops: 16 kept, last dropped.
    for (int i = 0; i < 17; i++) send(8'(i), 1, 0, 0);
    tick(2);
    check("t4_count", COUNT, DEPTH);
    check("t4_head", DATA, 8'h00);
    check_flags("t4");
    clear_flags("t4_clr");

    // Full FIFO: one pop coincides with the push, so nothing is lost.
    fork
      send(8'hC5, 1, 0, 1);
      begin
        tick(LAT - 1);
        ready_man = 1;
        tick(1);
        ready_man = 0;
      end
    join
    tick(2);
    check("t5_count", COUNT, DEPTH);
    check_flags("t5");
    drain("t5");

    // Reset during data bit 4 discards the partial frame.
    b = 8'h96;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    RXD = b[4];
    tick(CPB / 2);
    RESET = 1'b0;
    RXD   = 1'b1;
    exp_q.delete();
    model_frame = 0;
    model_ovr   = 0;
    model_par   = 0;
    tick(3);
    check("t6_rst_count", COUNT, 0);
    check("t6_rst_valid", VALID, 0);
    RESET = 1'b1;
    tick(CPB);
    lat_armed = 1;
    send(8'h3C, 1, 0, 0);
    tick(2);
    check("t6_valid_rose", lat_armed, 0);
    check("t6_count", COUNT, 1);
    check("t6_data", DATA, 8'h3C);
    check_flags("t6");
    drain("t6");
    if (PAR_EN) begin
      send(8'h3C, 1, 1, 0);
      tick(2);
      check("t6p_count", COUNT, 0);
      check_flags("t6p");
      clear_flags("t6p_clr");
    end

    // Randomised frames with random READY against the queue model.
    rand_en = 1;
    for (int k = 0; k < 20; k++) begin
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 7) != 0);
      pflip = ($urandom_range(0, 7) == 0);
      send(b, stop, pflip, 0);
      if (!stop) tick(CPB);
      else if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2 * CPB));
    end
    rand_en = 0;
    tick(2);
    drain("rnd");
    check_flags("rnd");
    clear_flags("rnd_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
